// File: rtl/posit_defines_es3.sv
// posit_defines_es3: shared types and constants for the es=3 posit stream reduction blocks.
package posit_defines_es3;
  typedef enum logic [1:0] {FLUSH, ACCUM, OUTPUT} sum_state_t;
  typedef enum logic [1:0] {PAIR_RH, PAIR_RI, PAIR_IH} pair_sel_t;
  localparam logic [31:0] POSIT_NAR  = 32'h8000_0000;
  localparam logic [31:0] POSIT_ZERO = 32'h0;
endpackage

// File: rtl/posit_sum_pairing_sel.sv
// posit_sum_pairing_sel: picks which two of result/input/hold feed the adder, or which single value parks in hold.
module posit_sum_pairing_sel
  import posit_defines_es3::*;
(
  input  logic      accum,
  input  logic      seen_last,
  input  logic      result_valid,
  input  logic      in_valid,
  input  logic      hold_valid,
  output logic      in_ready,
  output logic      issue,
  output logic      hold_wr,
  output logic      hold_from_result,
  output pair_sel_t sel
);
  logic r, i;
  always_comb begin
    in_ready = accum & ~seen_last & ~(result_valid & hold_valid);
    r = accum & result_valid;
    i = in_valid & in_ready;
    issue = (r & hold_valid) | (r & i) | (i & hold_valid);
    sel = (r & hold_valid) ? PAIR_RH : r ? PAIR_RI : PAIR_IH;
    hold_wr = (r ^ i) & ~hold_valid;
    hold_from_result = r;
  end
endmodule

// File: rtl/posit_stream_sum_8_es3.sv
// posit_stream_sum_8_es3: reduces a valid/ready stream of 32-bit es=3 posits to one sum through an external pipelined adder.
// Optional POSIT_STREAM_SUM_PERF_EN adds perf_cycles (first accept to out_valid, saturating).
module posit_stream_sum_8_es3
  import posit_defines_es3::*;
#(
  parameter int ADD_LATENCY = 8,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  output logic        add_start,
  input  logic [31:0] add_result,
  input  logic        add_done
`ifdef POSIT_STREAM_SUM_PERF_EN
  , output logic [31:0] perf_cycles
`endif
);
  sum_state_t       state;
  pair_sel_t        sel;
  logic [CNT_W-1:0] flush_cnt, inflight;
  logic [31:0]      hold, op_a, op_b;
  logic             hold_valid, seen_last, issue, hold_wr, hold_from_result, done, accept;

  posit_sum_pairing_sel u_sel (
    .accum           (state == ACCUM),
    .seen_last       (seen_last),
    .result_valid    (add_done),
    .in_valid        (in_valid),
    .hold_valid      (hold_valid),
    .in_ready        (in_ready),
    .issue           (issue),
    .hold_wr         (hold_wr),
    .hold_from_result(hold_from_result),
    .sel             (sel)
  );

  // operand A is always the older of the two values
  assign op_a   = (sel == PAIR_RI) ? add_result : hold;
  assign op_b   = (sel == PAIR_RH) ? add_result : in_data;
  assign accept = in_valid & in_ready;
  assign done   = (state == ACCUM) & seen_last & (inflight == '0) & ~add_done & ~issue & hold_valid;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= FLUSH;
      flush_cnt  <= '0;
      inflight   <= '0;
      hold       <= POSIT_ZERO;
      hold_valid <= 1'b0;
      seen_last  <= 1'b0;
      add_in1    <= POSIT_ZERO;
      add_in2    <= POSIT_ZERO;
      add_start  <= 1'b0;
      out_data   <= POSIT_ZERO;
      out_valid  <= 1'b0;
    end else begin
      add_start <= issue;
      if (issue) begin
        add_in1 <= op_a;
        add_in2 <= op_b;
      end
      if (state != FLUSH)
        inflight <= inflight + CNT_W'(issue) - CNT_W'(add_done);
      if (hold_wr) begin
        hold       <= hold_from_result ? add_result : in_data;
        hold_valid <= 1'b1;
      end else if (issue | done)
        hold_valid <= 1'b0;
      if (accept & in_last)
        seen_last <= 1'b1;
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
        if (flush_cnt == CNT_W'(ADD_LATENCY)) state <= ACCUM;
      end else if (done) begin
        out_data  <= hold;
        out_valid <= 1'b1;
        state     <= OUTPUT;
      end else if (state == OUTPUT && out_ready) begin
        out_valid <= 1'b0;
        seen_last <= 1'b0;
        state     <= ACCUM;
      end
    end

`ifdef POSIT_STREAM_SUM_PERF_EN
  logic [31:0] perf_cnt;
  logic        perf_run;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_cnt    <= '0;
      perf_run    <= 1'b0;
      perf_cycles <= '0;
    end else begin
      if (accept & ~perf_run) begin
        perf_run <= 1'b1;
        perf_cnt <= 32'd1;
      end else if (perf_run)
        perf_cnt <= perf_cnt + {31'b0, ~&perf_cnt};
      if (done) begin
        perf_cycles <= perf_cnt;
        perf_run    <= 1'b0;
      end
    end
`endif

  a_inflight: assert property (@(posedge clk) disable iff (reset) inflight <= CNT_W'(ADD_LATENCY + 1));
endmodule

// File: tb/tb_posit_stream_sum_8_es3.sv
// tb_posit_stream_sum_8_es3: directed and random streams against a real-arithmetic posit model and a behavioural adder pipeline.
module tb_posit_stream_sum_8_es3;
  localparam int LAT = 8;
  localparam logic [31:0] ONE = 32'h4000_0000, TWO = 32'h4400_0000, NAR = 32'h8000_0000;

  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_last = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, out_valid, add_start, add_done;
  logic [31:0] out_data, add_in1, add_in2, add_result;
  logic [LAT-1:0] pv = '0;
  logic [31:0] pr [LAT];
  logic [31:0] elems [$];
  int total = 0, bad = 0, starts = 0, cyc = 0, last_acc = 0, out_cyc = 0, lat = 0;

  always #5 clk = ~clk;

  posit_stream_sum_8_es3 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start), .add_result(add_result),
    .add_done(add_done)
  );

  function automatic real pow2(input int s);
    real r = 1.0;
    if (s >= 0) repeat (s) r = r * 2.0;
    else repeat (-s) r = r / 2.0;
    return r;
  endfunction

  function automatic real p2r(input logic [31:0] p);
    logic [31:0] q;
    int i, k, e;
    real f, w;
    if (p == 32'h0) return 0.0;
    q = p[31] ? -p : p;
    i = 30;
    k = 0;
    if (q[30]) begin
      k = -1;
      while (i >= 0 && q[i]) begin k++; i--; end
    end else
      while (i >= 0 && !q[i]) begin k--; i--; end
    i--;
    e = 0;
    for (int j = 0; j < 3; j++) begin e = e * 2 + ((i >= 0 && q[i]) ? 1 : 0); i--; end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (q[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    return (p[31] ? -f : f) * pow2(8 * k + e);
  endfunction

  function automatic logic [31:0] r2p(input real x);
    logic [127:0] b;
    logic [30:0] m;
    real v, f;
    int s, k, e, pos;
    logic neg, g, st;
    if (x == 0.0) return 32'h0;
    neg = x < 0.0;
    v = neg ? -x : x;
    s = 0;
    while (v >= 2.0) begin v = v / 2.0; s++; end
    while (v < 1.0) begin v = v * 2.0; s--; end
    k = s >= 0 ? s / 8 : -((7 - s) / 8);
    e = s - 8 * k;
    b = '0;
    pos = 127;
    if (k >= 0) begin
      repeat (k + 1) begin b[pos] = 1'b1; pos--; end
      pos--;
    end else begin
      pos = pos + k;
      b[pos] = 1'b1;
      pos--;
    end
    for (int j = 2; j >= 0; j--) begin b[pos] = e[j]; pos--; end
    f = v - 1.0;
    while (pos > 40) begin
      f = f * 2.0;
      b[pos] = (f >= 1.0);
      if (f >= 1.0) f = f - 1.0;
      pos--;
    end
    m = b[127:97];
    g = b[96];
    st = |b[95:0];
    if (g && (st || m[0])) m = m + 31'd1;
    return neg ? -{1'b0, m} : {1'b0, m};
  endfunction

  function automatic logic [31:0] padd(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    return r2p(p2r(a) + p2r(b));
  endfunction

  // behavioural adder: keeps running through reset so stale results really arrive during flush
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv <= {pv[LAT-2:0], add_start};
    pr[0] <= padd(add_in1, add_in2);
    for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
    if (add_start) starts <= starts + 1;
  end
  assign add_done   = pv[LAT-1];
  assign add_result = pr[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    while (in_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    chk("accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    last_acc = cyc;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic recv(input string tag, input logic [31:0] exp, input int stall);
    int t = 0;
    logic [31:0] snap;
    logic ok;
    while (out_valid !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    out_cyc = cyc;
    chk(tag, out_data, exp);
    snap = out_data;
    ok = 1;
    repeat (stall) begin
      @(negedge clk);
      ok = ok & (out_data === snap) & (out_valid === 1'b1) & (in_ready === 1'b0);
    end
    if (stall > 0) chk({tag, "_stall"}, 32'(ok), 32'd1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_clear"}, 32'(out_valid), 32'd0);
  endtask

  task automatic stream(input string tag, input logic [31:0] exp, input int gap, input int stall);
    int base = starts, first = 0;
    foreach (elems[i]) begin
      send(elems[i], i == elems.size() - 1);
      if (i == 0) first = last_acc;
      repeat (gap) @(negedge clk);
    end
    recv(tag, exp, stall);
    lat = out_cyc - first;
    chk({tag, "_adds"}, 32'(starts - base), 32'(elems.size() - 1));
  endtask

  initial begin
    int n, v, sum, base, gap, stall;
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_add_start", 32'(add_start), 32'd0);
    chk("rst_add_in1", add_in1, 32'd0);
    reset = 0;

    elems = '{ONE, ONE, ONE, ONE};
    stream("four_ones", 32'h4800_0000, 0, 0);
    chk("four_ones_latency", 32'(lat <= 4 + 2 * (LAT + 1) + 3), 32'd1);

    base = starts;
    send(32'h4600_0000, 1'b1);
    chk("single_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_on_time", 32'(out_valid), 32'd1);
    recv("single", 32'h4600_0000, 0);
    chk("single_no_add", 32'(starts - base), 32'd0);

    elems = '{ONE, TWO};
    stream("gap", 32'h4600_0000, 5, 0);

    elems = '{ONE, ONE, NAR, ONE, ONE, ONE};
    stream("nar", NAR, 0, 0);

    elems = '{TWO, ONE};
    stream("stall", 32'h4600_0000, 0, 20);
    elems = '{ONE, ONE};
    stream("after_stall", TWO, 0, 0);
    chk("after_stall_latency", 32'(lat <= 2 + (LAT + 1) + 3), 32'd1);

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) send(ONE, 1'b0);
      else send(ONE, 1'b0);
    end
    reset = 1;
    repeat (2) @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    reset = 0;
    seen = 0;
    repeat (12) begin @(negedge clk); seen = seen | out_valid; end
    chk("midrst_no_output", 32'(seen), 32'd0);
    elems = '{TWO, TWO};
    stream("midrst_sum", 32'h4800_0000, 0, 0);

    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 12);
      gap = $urandom_range(0, 2);
      stall = $urandom_range(0, 4);
      sum = 0;
      elems = {};
      repeat (n) begin
        v = int'($urandom_range(0, 16)) - 8;
        sum += v;
        elems.push_back(r2p(real'(v)));
      end
      stream($sformatf("rand%0d", s), r2p(real'(sum)), gap, stall);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/posit_stream_sum_8_es3.md
Name: posit_stream_sum_8_es3

Overview:
- Streaming reduction controller for 32-bit posit values (es=3).
- Accepts a valid/ready stream of posits terminated by a `last` flag and returns a single sum per stream.
- Sits both upstream and downstream of the pipelined posit adder: it issues operand pairs on the adder's in1/in2/start and consumes its result/done.
- Partial sums re-circulate through the adder pipeline until a single value remains.

Parameters:
- ADD_LATENCY, 8: cycles from adder start sampled to done; sets the post-reset flush length.
- CNT_W, 8: width of the in-flight counter; must satisfy 2^CNT_W > ADD_LATENCY+1.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  input element accepted when in_valid&in_ready
- in_data  in  32  posit operand
- in_last  in  1  marks final element of current stream
- out_valid  out  1  sum valid
- out_ready  in  1  consumer accepts sum
- out_data  out  32  posit sum of stream
- add_in1  out  32  adder operand A (registered)
- add_in2  out  32  adder operand B (registered)
- add_start  out  1  adder start (registered, one-cycle pulse per pair)
- add_result  in  32  adder result
- add_done  in  1  adder result valid

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, add_in1=0, add_in2=0, add_start=0, hold_valid=0, inflight=0, seen_last=0, state=FLUSH.
- FLUSH state:
  - A counter runs for ADD_LATENCY+1 cycles after reset deasserts.
  - add_done is ignored throughout, discarding stale adder results.
  - Then go to ACCUM.
- ACCUM state, value sources per cycle: R = add_done (result), I = in_valid&in_ready, H = hold register.
- Pairing priority:
  - R&H: issue (hold, result).
  - R&I: issue (result, in_data).
  - I&H: issue (hold, in_data).
  - Single R or I: write it to hold.
- in_ready = (state==ACCUM) & ~seen_last & ~(add_done & hold_valid). If result and hold are both present, input stalls.
- Issue registers add_in1/add_in2 and pulses add_start next cycle. Operand A is always the older value.
- inflight counter:
  - +1 on issue, -1 on add_done (outside FLUSH).
  - Simultaneous issue and done leave it unchanged.
- seen_last is set when in_last is accepted.
- Completion condition: seen_last & inflight==0 & ~add_done & ~issue pending & hold_valid.
  - When it holds: out_data<=hold, out_valid<=1, hold_valid<=0, state→OUTPUT.
- OUTPUT state: hold out_data/out_valid stable until out_ready; then clear out_valid and seen_last, state→ACCUM.
- Single-element stream: the element goes to hold and is output 1 cycle after acceptance, unmodified.
- Latency for an N-element stream (N≥2, back-to-back input) is bounded by N + ceil(log2 N)·(ADD_LATENCY+1) + 3 cycles from first accept.
- Special values need no special handling: zero and NaR pass through the adder unchanged.
- Reset mid-stream: all state cleared, partial sum lost, re-enter FLUSH. No out_valid for the aborted stream.
- inflight must never exceed ADD_LATENCY+1; simulation assertion if it does.

Optional Feature:
- Macro: POSIT_STREAM_SUM_PERF_EN.
- When defined:
  - Adds output port perf_cycles (32-bit).
  - Counts cycles from first accepted element to out_valid rising, saturating at 0xFFFFFFFF.
  - Latched with out_data and held stable through OUTPUT; reset value 0.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package posit_defines_es3 gets:
  - sum_state_t enum (FLUSH, ACCUM, OUTPUT);
  - localparam POSIT_NAR = 32'h80000000;
  - localparam POSIT_ZERO = 32'h0.
- One sub-module: posit_sum_pairing_sel, combinational. Inputs are the R/I/H availability flags; outputs are the issue select, hold write and in_ready.
- The adder is instantiated by the parent, not inside this block.

Test Plan:
- Four 1.0 (0x40000000) back-to-back, last on 4th → out_data 0x48000000 (4.0); inflight returns to 0.
- Single element 0x46000000 (3.0) with last → out_data 0x46000000 one cycle after accept; add_start never pulses.
- 1.0, 2.0 (0x44000000), with in_valid gaps of 5 cycles → 0x46000000; no double issue, hold used.
- Stream containing NaR 0x80000000 among five 1.0 → out_data 0x80000000.
- out_ready held low 20 cycles → out_data stable and in_ready=0 throughout; next stream (2×1.0 → 0x44000000) correct after release.
- Assert reset mid-stream with 3 adds in flight, then send 2×2.0 → stale add_done ignored during FLUSH; out_data 0x48000000 only.
